// File: rtl/fetch_mem_arbiter.sv
// ---------------------------------------------------------------------------
// fetch_mem_arbiter
// Round-robin arbiter between the instruction fetchers and the program-memory
// read channels. Each channel runs its own IDLE -> READ_WAITING -> RELAYING
// FSM; the returned instruction word goes back to the fetcher that owns the
// channel and is held until that fetcher drops its request.
//
// Ports:
//   clk                   clock, all state updates on the rising edge
//   reset                 asynchronous active-low reset
//   consumer_read_valid   per-fetcher request, held until served
//   consumer_read_address per-fetcher PC
//   consumer_read_ready   per-fetcher data-valid strobe (registered)
//   consumer_read_data    per-fetcher returned instruction (registered)
//   mem_read_valid        per-channel memory request (registered)
//   mem_read_address      per-channel memory address (registered)
//   mem_read_ready        per-channel memory response valid
//   mem_read_data         per-channel memory response data
// ---------------------------------------------------------------------------
module fetch_mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_CONSUMERS-1:0]                  consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_read_data,
  output logic [NUM_CHANNELS-1:0]                   mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                   mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    mem_read_data
);

  localparam int          PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int unsigned NC_U  = 32'(NUM_CONSUMERS);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_READ_WAITING = 2'd1,
    ST_RELAYING     = 2'd2
  } state_t;

  state_t                                 state_r [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0][PTR_W-1:0]     owner_r;
  logic [NUM_CONSUMERS-1:0]               claim_r;
  logic [PTR_W-1:0]                       rr_ptr_r;

  logic [NUM_CHANNELS-1:0]                grant_s;
  logic [NUM_CHANNELS-1:0][PTR_W-1:0]     winner_s;
  logic [PTR_W-1:0]                       rr_next_s;

  // (base + off) modulo NUM_CONSUMERS, for off < NUM_CONSUMERS
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int unsigned     off);
    int unsigned sum_v;
    sum_v = 32'(base) + off;
    if (sum_v >= NC_U) begin
      sum_v = sum_v - NC_U;
    end else begin
      sum_v = sum_v;
    end
    return sum_v[PTR_W-1:0];
  endfunction

  // Grant selection: channels pick in ascending order, each seeing the claims
  // and round-robin pointer left by the lower-numbered channels this cycle.
  always_comb begin : arb_comb
    logic [NUM_CONSUMERS-1:0] claim_v;
    logic [PTR_W-1:0]         ptr_v;
    logic [PTR_W-1:0]         idx_v;
    logic [PTR_W-1:0]         win_v;
    logic                     found_v;
    claim_v  = claim_r;
    ptr_v    = rr_ptr_r;
    idx_v    = '0;
    win_v    = '0;
    found_v  = 1'b0;
    grant_s  = '0;
    winner_s = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      found_v = 1'b0;
      win_v   = '0;
      if (state_r[c] == ST_IDLE) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          idx_v = wrap_idx(ptr_v, 32'(k));
          if (!found_v && consumer_read_valid[idx_v] && !claim_v[idx_v]) begin
            found_v = 1'b1;
            win_v   = idx_v;
          end else begin
          end
        end
        if (found_v) begin
          claim_v[win_v] = 1'b1;
          ptr_v          = wrap_idx(win_v, 32'd1);
          grant_s[c]     = 1'b1;
          winner_s[c]    = win_v;
        end else begin
        end
      end else begin
      end
    end
    rr_next_s = ptr_v;
  end

  // Per-channel FSMs, claim bits, round-robin pointer and all outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_r[c] <= ST_IDLE;
      end
      owner_r             <= '0;
      claim_r             <= '0;
      rr_ptr_r            <= '0;
      mem_read_valid      <= '0;
      mem_read_address    <= '0;
      consumer_read_ready <= '0;
      consumer_read_data  <= '0;
    end else begin
      rr_ptr_r <= rr_next_s;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        case (state_r[c])
          ST_IDLE: begin
            if (grant_s[c]) begin
              claim_r[winner_s[c]] <= 1'b1;
              owner_r[c]           <= winner_s[c];
              mem_read_valid[c]    <= 1'b1;
              mem_read_address[c]  <= consumer_read_address[winner_s[c]];
              state_r[c]           <= ST_READ_WAITING;
            end
          end
          ST_READ_WAITING: begin
            // The read completes even if the fetcher already gave up.
            if (mem_read_ready[c]) begin
              consumer_read_data[owner_r[c]]  <= mem_read_data[c];
              consumer_read_ready[owner_r[c]] <= 1'b1;
              mem_read_valid[c]               <= 1'b0;
              state_r[c]                      <= ST_RELAYING;
            end
          end
          ST_RELAYING: begin
            if (!consumer_read_valid[owner_r[c]]) begin
              consumer_read_ready[owner_r[c]] <= 1'b0;
              claim_r[owner_r[c]]             <= 1'b0;
              state_r[c]                      <= ST_IDLE;
            end
          end
          default: begin
            mem_read_valid[c] <= 1'b0;
            state_r[c]        <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fetch_mem_arbiter
// Directed bench: one single-channel instance (u_dut1) and one dual-channel
// instance (u_dut2) sharing clock and reset. Inputs change and outputs are
// checked 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic reset;

  // single-channel instance
  logic [NC-1:0]          v1;
  logic [NC-1:0][AW-1:0]  a1;
  logic [NC-1:0]          r1;
  logic [NC-1:0][DW-1:0]  d1;
  logic [0:0]             mv1;
  logic [0:0][AW-1:0]     ma1;
  logic [0:0]             mr1;
  logic [0:0][DW-1:0]     md1;

  // dual-channel instance
  logic [NC-1:0]          v2;
  logic [NC-1:0][AW-1:0]  a2;
  logic [NC-1:0]          r2;
  logic [NC-1:0][DW-1:0]  d2;
  logic [1:0]             mv2;
  logic [1:0][AW-1:0]     ma2;
  logic [1:0]             mr2;
  logic [1:0][DW-1:0]     md2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(NC), .NUM_CHANNELS(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(v1), .consumer_read_address(a1),
    .consumer_read_ready(r1), .consumer_read_data(d1),
    .mem_read_valid(mv1), .mem_read_address(ma1),
    .mem_read_ready(mr1), .mem_read_data(md1)
  );

  fetch_mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(NC), .NUM_CHANNELS(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(v2), .consumer_read_address(a2),
    .consumer_read_ready(r2), .consumer_read_data(d2),
    .mem_read_valid(mv2), .mem_read_address(ma2),
    .mem_read_ready(mr2), .mem_read_data(md2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Wait (bounded) for the single-channel memory request to appear.
  task automatic wait_mv1(input string tag);
    for (int w = 0; w < 8 && mv1 !== 1'b1; w++) tick();
    chk(tag, 64'(mv1), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    v1 = '0; a1 = '0; mr1 = '0; md1 = '0;
    v2 = '0; a2 = '0; mr2 = '0; md2 = '0;
    tick();
    tick();
    // reset state
    chk("rst_mv1",   64'(mv1), 64'd0);
    chk("rst_ma1",   64'(ma1), 64'd0);
    chk("rst_r1",    64'(r1),  64'd0);
    chk("rst_d1",    64'(d1),  64'd0);
    chk("rst_mv2",   64'(mv2), 64'd0);
    chk("rst_r2",    64'(r2),  64'd0);
    reset = 1'b1;

    // ---- single request: consumer 2, addr 0x1A, memory answers 3 cycles later
    a1[2] = 8'h1A;
    v1[2] = 1'b1;
    tick();
    chk("single_mv",   64'(mv1),   64'd1);
    chk("single_addr", 64'(ma1[0]), 64'h1A);
    chk("single_r0",   64'(r1),    64'h0);
    tick();
    tick();
    chk("single_wait", {56'd0, 8'(ma1[0])} | (64'(mv1) << 8), 64'h11A);
    mr1 = 1'b1; md1[0] = 16'hBEEF;
    tick();
    mr1 = 1'b0; md1[0] = 16'h0000;
    chk("single_rdy1", 64'(r1),    64'b0100);
    chk("single_data", 64'(d1[2]), 64'hBEEF);
    chk("single_mv0",  64'(mv1),   64'd0);
    tick();
    chk("single_rdy2", 64'(r1),    64'b0100);
    chk("single_dat2", 64'(d1[2]), 64'hBEEF);
    v1[2] = 1'b0;
    tick();
    chk("single_rdy0", 64'(r1),    64'b0000);
    chk("single_keep", 64'(d1[2]), 64'hBEEF);

    // ---- round-robin fairness: all four request continuously
    reset_pulse();
    a1[0] = 8'h10; a1[1] = 8'h11; a1[2] = 8'h12; a1[3] = 8'h13;
    v1 = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      int e;
      e = n % 4;
      wait_mv1("rr_mv");
      chk("rr_addr", 64'(ma1[0]), 64'(8'h10 + 8'(e)));
      mr1 = 1'b1; md1[0] = 16'hA000 + 16'(n);
      tick();
      mr1 = 1'b0;
      chk("rr_rdy",  64'(r1),    64'(4'b0001 << e));
      chk("rr_data", 64'(d1[e]), 64'(16'hA000 + 16'(n)));
      tick();
      v1[e] = 1'b0;
      if (n == 5) v1 = '0;
      tick();
      chk("rr_rel", 64'(r1), 64'd0);
      if (n != 5) v1[e] = 1'b1;
    end

    // ---- slow memory: 20 cycles of backpressure (rr pointer now 2)
    a1[1] = 8'h77;
    v1[1] = 1'b1;
    tick();
    chk("slow_grant", {55'd0, mv1, ma1[0]}, 64'h177);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("slow_hold", {51'd0, mv1, ma1[0], r1}, {51'd0, 1'b1, 8'h77, 4'h0});
    end
    mr1 = 1'b1; md1[0] = 16'hC0DE;
    tick();
    mr1 = 1'b0;
    chk("slow_rdy",  64'(r1),    64'b0010);
    chk("slow_data", 64'(d1[1]), 64'hC0DE);
    tick();
    v1[1] = 1'b0;
    tick();
    chk("slow_rel", 64'(r1), 64'd0);

    // ---- reset asserted between edges while READ_WAITING
    a1[3] = 8'h5C;
    v1[3] = 1'b1;
    tick();
    chk("mrst_grant", {55'd0, mv1, ma1[0]}, 64'h15C);
    #3;
    reset = 1'b0;
    #1;
    chk("mrst_mv",   64'(mv1),    64'd0);
    chk("mrst_addr", 64'(ma1[0]), 64'd0);
    chk("mrst_rdy",  64'(r1),     64'd0);
    chk("mrst_data", 64'(d1),     64'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("mrst_reissue", {55'd0, mv1, ma1[0]}, 64'h15C);
    mr1 = 1'b1; md1[0] = 16'h5555;
    tick();
    mr1 = 1'b0;
    chk("mrst_rdy1", 64'(r1),    64'b1000);
    chk("mrst_dat",  64'(d1[3]), 64'h5555);
    tick();
    v1[3] = 1'b0;
    tick();

    // ---- early valid drop by consumer 0 (rr pointer now 0)
    a1[0] = 8'h20;
    v1[0] = 1'b1;
    tick();
    chk("drop_grant", {55'd0, mv1, ma1[0]}, 64'h120);
    v1[0] = 1'b0;
    a1[1] = 8'h21;
    v1[1] = 1'b1;
    tick();
    chk("drop_busy", {55'd0, mv1, ma1[0]}, 64'h120);
    mr1 = 1'b1; md1[0] = 16'h0F0F;
    tick();
    mr1 = 1'b0;
    chk("drop_rdy1", 64'(r1),    64'b0001);
    chk("drop_data", 64'(d1[0]), 64'h0F0F);
    tick();
    chk("drop_rdy0", 64'(r1),  64'b0000);
    chk("drop_idle", 64'(mv1), 64'd0);
    tick();
    chk("drop_next", {55'd0, mv1, ma1[0]}, 64'h121);
    mr1 = 1'b1; md1[0] = 16'h2222;
    tick();
    mr1 = 1'b0;
    chk("drop_n_rdy",  64'(r1),    64'b0010);
    chk("drop_n_data", 64'(d1[1]), 64'h2222);
    chk("drop_retain", 64'(d1[0]), 64'h0F0F);
    tick();
    v1[1] = 1'b0;
    tick();

    // ---- two channels, consumers 1 and 3 in the same cycle
    a2[1] = 8'h31; a2[3] = 8'h33;
    v2 = 4'b1010;
    tick();
    chk("dual_mv",    64'(mv2),    64'b11);
    chk("dual_addr0", 64'(ma2[0]), 64'h31);
    chk("dual_addr1", 64'(ma2[1]), 64'h33);
    mr2 = 2'b11; md2[0] = 16'h1111; md2[1] = 16'h3333;
    tick();
    mr2 = 2'b00;
    chk("dual_rdy",   64'(r2),     64'b1010);
    chk("dual_data1", 64'(d2[1]),  64'h1111);
    chk("dual_data3", 64'(d2[3]),  64'h3333);
    chk("dual_mv0",   64'(mv2),    64'b00);
    tick();
    v2 = 4'b0000;
    tick();
    chk("dual_rel",   64'(r2),     64'd0);
    tick();
    chk("dual_nodup", 64'(mv2),    64'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
